// File: rtl/edge_arb_pkg.sv
// Shared defaults and types for the edge event arbiter.
// Optional timestamp types are compiled only with EDGE_ARB_TIMESTAMP_EN.
package edge_arb_pkg;

    localparam int DEF_NUM_CH = 4;

    typedef logic [$clog2(DEF_NUM_CH)-1:0] ch_idx_t;

`ifdef EDGE_ARB_TIMESTAMP_EN
    localparam int DEF_TS_W = 16;

    typedef logic [DEF_TS_W-1:0] ts_t;
`endif

endpackage

// File: rtl/edge_event_arbiter_rr.sv
// Combinational round-robin pick: the first request searching upward from ptr+1,
// wrapping at NUM_CH.
module edge_rr_arbiter
    import edge_arb_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [CH_W-1:0]   ptr_i,
    output logic              gnt_valid_o,
    output logic [CH_W-1:0]   gnt_idx_o
);

    // Walk the candidates farthest-first so the nearest one after ptr wins.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            int j;
            j = (int'(ptr_i) + k) % NUM_CH;
            if (req_i[j]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = CH_W'(j);
            end
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Rising-edge event collector: per-channel pending flags served round-robin onto
// a valid/ready port. EDGE_ARB_TIMESTAMP_EN adds a cycle counter and evt_ts_o.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = $clog2(NUM_CH)
`ifdef EDGE_ARB_TIMESTAMP_EN
    ,
    parameter int TS_W   = DEF_TS_W
`endif
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [NUM_CH-1:0] signal_i,
    input  logic [NUM_CH-1:0] ch_en_i,
    output logic              evt_valid_o,
    input  logic              evt_ready_i,
    output logic [CH_W-1:0]   evt_ch_o,
    output logic [NUM_CH-1:0] overflow_o,
    input  logic [NUM_CH-1:0] ovf_clr_i
`ifdef EDGE_ARB_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]   evt_ts_o
`endif
);

    logic [NUM_CH-1:0] sig_q;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic              valid_q, valid_d;
    logic [CH_W-1:0]   ch_q, ch_d;

    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] take;
    logic              load;
    logic              gnt_valid;
    logic [CH_W-1:0]   gnt_idx;

    assign req = pend_q & ch_en_i;

    edge_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr (
        .req_i       (req),
        .ptr_i       (ptr_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    // A rise on a channel being loaded this cycle re-arms it as a fresh event.
    always_comb begin
        load    = !valid_q || evt_ready_i;
        rise    = signal_i & ~sig_q & ch_en_i;
        take    = '0;
        valid_d = valid_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        if (load) begin
            valid_d = gnt_valid;
            if (gnt_valid) begin
                take[gnt_idx] = 1'b1;
                ch_d          = gnt_idx;
                ptr_d         = gnt_idx;
            end
        end
        pend_d = ((pend_q & ~take) | rise) & ch_en_i;
        ovf_d  = (ovf_q & ~ovf_clr_i) | (rise & pend_q & ~take);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sig_q   <= '1;
            pend_q  <= '0;
            ovf_q   <= '0;
            ptr_q   <= CH_W'(NUM_CH - 1);
            valid_q <= 1'b0;
            ch_q    <= '0;
        end else begin
            sig_q   <= signal_i;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            ch_q    <= ch_d;
        end
    end

    assign evt_valid_o = valid_q;
    assign evt_ch_o    = ch_q;
    assign overflow_o  = ovf_q;

`ifdef EDGE_ARB_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_q;
    logic [TS_W-1:0] ts_q [NUM_CH];
    logic [TS_W-1:0] evt_ts_q;

    // Stamp the first edge of each new event; coalesced edges keep the older stamp.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ts_cnt_q <= '0;
            evt_ts_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ts_q[i] <= '0;
            end
        end else begin
            ts_cnt_q <= ts_cnt_q + 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (rise[i] && (!pend_q[i] || take[i])) begin
                    ts_q[i] <= ts_cnt_q;
                end
            end
            if (load && gnt_valid) begin
                evt_ts_q <= ts_q[gnt_idx];
            end
        end
    end

    assign evt_ts_o = evt_ts_q;
`endif

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Multi-channel rising-edge event collector and scheduler.
- Detects positive edges on NUM_CH synchronous level inputs and holds one pending flag per channel.
- Serialises pending events onto a single valid/ready event port using round-robin arbitration.
- Sits between the per-signal edge-detection front end and the single downstream event consumer (interrupt/log block).

Parameters:
- NUM_CH, 4: number of input channels (2..16).
- CH_W, $clog2(NUM_CH): width of the channel-index output.
- TS_W, 16: timestamp width; used only when EDGE_ARB_TIMESTAMP_EN is defined.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- signal  in  NUM_CH  level inputs, already synchronous to clk.
- ch_en  in  NUM_CH  per-channel enable.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event when evt_valid&&evt_ready.
- evt_ch  out  CH_W  channel index of the current event.
- overflow  out  NUM_CH  sticky per-channel lost-event flags.
- ovf_clr  in  NUM_CH  write-1-to-clear for overflow.

Behaviour:
- Reset (async, rstn=0):
  - evt_valid=0, evt_ch=0, overflow=0.
  - All pending flags=0.
  - Round-robin pointer=NUM_CH-1, so channel 0 has first priority.
  - Delayed-input register sig_d=all ones, so a level already high when reset releases is not an edge.
- Edge detect: rise[i] = signal[i] & ~sig_d[i] & ch_en[i]; sig_d <= signal every cycle regardless of ch_en.
- Pending set: pend[i] is set on rise[i].
- Pending cleared:
  - when channel i is loaded into the output register; or
  - when ch_en[i]=0, which also discards the flag.
- Output load condition: load = !evt_valid || evt_ready.
  - When load is true and any pend is set, the arbiter picks the first set channel searching from ptr+1 upward, wrapping at NUM_CH.
  - Next cycle: evt_valid=1, evt_ch=pick. Pointer <= pick.
  - When load is true and no pend is set, evt_valid <= 0.
- Hold rule: while evt_valid && !evt_ready, evt_ch (and evt_ts, if present) stay stable, and pend and ptr do not advance.
- Latency: the edge is sampled at clock k; pend is set after edge k; evt_valid is asserted after edge k+1 if the output is free. Minimum latency is 2 cycles.
- Throughput: 1 event/cycle with evt_ready held high.
- Boundary cases:
  - Rise on channel i while pend[i]=1 and i is not being loaded that cycle: overflow[i] <= 1, pend stays 1 (events coalesce).
  - Rise on channel i in the same cycle i is loaded: pend[i] stays 1 (new event), no overflow.
  - ovf_clr[i] in the same cycle as an overflow set on i: set wins.
  - ch_en deasserted while channel i occupies the output register: the in-flight event is still delivered.
  - All channels pending with evt_ready=1: grants run in strict rotation 0,1,2,3,0,...
  - Reset mid-transfer: the event is dropped and all state returns to reset values immediately.

Optional Feature:
- Macro: EDGE_ARB_TIMESTAMP_EN.
- Defined:
  - Free-running TS_W-bit cycle counter, reset to 0, wraps to 0 after all ones.
  - Per-channel ts register captures the counter on rise[i] when pend[i] was 0 (first edge of a coalesced burst).
  - Extra output evt_ts [TS_W-1:0] is loaded with evt_ch and obeys the same hold rule; evt_ts resets to 0.
- Undefined: no counter, no ts storage, no evt_ts port.

Decomposition:
- Package edge_arb_pkg:
  - default NUM_CH and TS_W localparams;
  - ch_idx_t typedef;
  - ts_t typedef, under the macro.
- One sub-module, edge_rr_arbiter: combinational round-robin pick.
  - Inputs: req[NUM_CH], ptr.
  - Outputs: gnt_valid, gnt_idx.
- All registers live in the top module.

Test Plan:
- Reset: hold rstn=0 with signal=4'b1111, then release → no events. Pulse signal[2] 0→1 → evt_valid=1 with evt_ch=2 exactly 2 cycles after the rising sample.
- Round-robin: all four channels rise in the same cycle, evt_ready=1 → evt_ch sequence 0,1,2,3 on consecutive cycles, then evt_valid=0.
- Backpressure: evt_ready=0 for 5 cycles with channels 1 and 3 pending → evt_ch=1 stays stable. Raise evt_ready → 1 accepted, then 3.
- Overflow: evt_ready=0 with channel 0 pending; channel 0 rises again → overflow[0]=1 and only one ch0 event is delivered. ovf_clr[0]=1 → overflow[0]=0.
- Enable/coincidence: ch_en[1]=0 while signal[1] pulses → no event. Channel 3 rises in the same cycle it is loaded → a second ch3 event follows and overflow[3]=0.
- Timestamp, macro defined: channel 2 rises when the counter reads 100 → delivered evt_ts=100 (the counter value at the edge), independent of delivery delay. Counter wraps 16'hFFFF→0.
